// File: rtl/imem_loader.sv
// imem_loader
//   Serial program loader for the instruction memory. Parses a length-prefixed,
//   checksummed byte stream, assembles little-endian 32-bit words and writes them
//   to consecutive word-aligned addresses. The CPU is held in reset until the
//   image checksum verifies.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx_data    received byte (qualified by rx_valid)
//   rx_valid   one-cycle strobe per received byte
//   restart    one-cycle pulse, returns DONE/ERROR to IDLE
//   mem_we     one-cycle write strobe per assembled word
//   mem_addr   word-aligned byte address of the write
//   mem_wdata  assembled word {b3,b2,b1,b0}
//   cpu_hold   1 = CPU held in reset
//   done       image loaded and verified (level)
//   error      load failed (level)
//   err_code   0 none, 1 length too large, 2 timeout, 3 checksum mismatch
module imem_loader #(
   parameter int MEM_WORDS      = 256,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        restart,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code
);

   // Idle counter only needs to count up to TIMEOUT_CYCLES-1; the edge that
   // would take it to TIMEOUT_CYCLES raises the timeout instead.
   localparam int          CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0] MAX_N   = 17'(MEM_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t         state_reg, state_next;
   logic [7:0]     len_lo_reg, len_lo_next;
   logic [15:0]    len_reg, len_next;
   logic [15:0]    idx_reg, idx_next;
   logic [1:0]     lane_reg, lane_next;
   logic [7:0]     csum_reg, csum_next;
   logic [CW-1:0]  idle_reg, idle_next;
   logic           we_reg, we_next;
   logic [31:0]    addr_reg, addr_next;
   logic [31:0]    wdata_reg, wdata_next;
   logic           hold_reg, hold_next;
   logic           done_reg, done_next;
   logic           error_reg, error_next;
   logic [1:0]     code_reg, code_next;

   logic [15:0]    n_val;
   logic           busy;
   logic           load_byte;
   logic [23:0]    lane_bytes;

   assign load_byte = (state_reg == S_DATA) && rx_valid;

   // Byte lanes 0..2 of the word under assembly; lane 3 goes straight from
   // rx_data into the write data, so it needs no storage.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         logic [7:0] b_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               b_reg <= '0;
            else if (load_byte && (lane_reg == 2'(gi)))
               b_reg <= rx_data;
         end
         assign lane_bytes[gi*8 +: 8] = b_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         len_lo_reg <= '0;
         len_reg    <= '0;
         idx_reg    <= '0;
         lane_reg   <= '0;
         csum_reg   <= '0;
         idle_reg   <= '0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         hold_reg   <= 1'b1;
         done_reg   <= 1'b0;
         error_reg  <= 1'b0;
         code_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         len_lo_reg <= len_lo_next;
         len_reg    <= len_next;
         idx_reg    <= idx_next;
         lane_reg   <= lane_next;
         csum_reg   <= csum_next;
         idle_reg   <= idle_next;
         we_reg     <= we_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         hold_reg   <= hold_next;
         done_reg   <= done_next;
         error_reg  <= error_next;
         code_reg   <= code_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      len_lo_next = len_lo_reg;
      len_next    = len_reg;
      idx_next    = idx_reg;
      lane_next   = lane_reg;
      csum_next   = csum_reg;
      idle_next   = '0;
      we_next     = 1'b0;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      hold_next   = hold_reg;
      done_next   = done_reg;
      error_next  = error_reg;
      code_next   = code_reg;
      n_val       = {rx_data, len_lo_reg};
      busy        = (state_reg == S_LEN_HI) || (state_reg == S_DATA) ||
                    (state_reg == S_CHECK);

      case (state_reg)
         S_IDLE: begin
            if (rx_valid) begin
               len_lo_next = rx_data;
               state_next  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (rx_valid) begin
               len_next  = n_val;
               idx_next  = '0;
               lane_next = '0;
               csum_next = '0;
               if ({1'b0, n_val} > MAX_N) begin
                  state_next = S_ERROR;
                  error_next = 1'b1;
                  code_next  = 2'd1;
               end else if (n_val == 16'd0) begin
                  state_next = S_CHECK;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               csum_next = csum_reg + rx_data;
               lane_next = lane_reg + 2'd1;
               if (lane_reg == 2'd3) begin
                  we_next    = 1'b1;
                  addr_next  = {14'd0, idx_reg, 2'b00};
                  wdata_next = {rx_data, lane_bytes};
                  if (idx_reg == len_reg - 16'd1)
                     state_next = S_CHECK;
                  else
                     idx_next = idx_reg + 16'd1;
               end
            end
         end
         S_CHECK: begin
            if (rx_valid) begin
               if (rx_data == csum_reg) begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
                  hold_next  = 1'b0;
               end else begin
                  state_next = S_ERROR;
                  error_next = 1'b1;
                  code_next  = 2'd3;
               end
            end
         end
         S_DONE, S_ERROR: begin
            if (restart) begin
               state_next = S_IDLE;
               done_next  = 1'b0;
               error_next = 1'b0;
               code_next  = 2'd0;
               hold_next  = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Inter-byte watchdog. A byte on the would-be timeout edge wins.
      if (busy) begin
         if (rx_valid) begin
            idle_next = '0;
         end else if (idle_reg == TO_LAST) begin
            state_next = S_ERROR;
            error_next = 1'b1;
            code_next  = 2'd2;
         end else begin
            idle_next = idle_reg + 1'b1;
         end
      end
   end

   assign mem_we    = we_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign cpu_hold  = hold_reg;
   assign done      = done_reg;
   assign error     = error_reg;
   assign err_code  = code_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        restart;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   logic [7:0] nom_bytes [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                                  8'h93, 8'h00, 8'h10, 8'h00};

   imem_loader #(.MEM_WORDS(256), .TIMEOUT_CYCLES(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .restart  (restart),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error),
      .err_code (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every write strobe away from the active edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; byte is sampled at the next edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic send_nominal(input logic [7:0] cs);
      for (int i = 0; i < 10; i++) send_byte(nom_bytes[i]);
      send_byte(cs);
   endtask

   task automatic check_nominal_writes(input string tag);
      check({tag, "_wcount"}, 32'(wr_addr_q.size()), 32'd2);
      if (wr_addr_q.size() == 2) begin
         check({tag, "_a0"}, wr_addr_q[0], 32'h0);
         check({tag, "_d0"}, wr_data_q[0], 32'h00500013);
         check({tag, "_a1"}, wr_addr_q[1], 32'h4);
         check({tag, "_d1"}, wr_data_q[1], 32'h00100093);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},    32'(mem_we),    32'd0);
      check({tag, "_addr"},  mem_addr,       32'd0);
      check({tag, "_wdata"}, mem_wdata,      32'd0);
      check({tag, "_hold"},  32'(cpu_hold),  32'd1);
      check({tag, "_done"},  32'(done),      32'd0);
      check({tag, "_error"}, 32'(error),     32'd0);
      check({tag, "_code"},  32'(err_code),  32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      restart  = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Nominal load, with per-cycle look at the first write strobe.
      clear_log();
      for (int i = 0; i < 6; i++) send_byte(nom_bytes[i]);
      check("nom_we_pulse", 32'(mem_we), 32'd1);
      check("nom_addr0", mem_addr, 32'h0);
      check("nom_data0", mem_wdata, 32'h00500013);
      send_byte(nom_bytes[6]);
      check("nom_we_low", 32'(mem_we), 32'd0);
      check("nom_data_hold", mem_wdata, 32'h00500013);
      for (int i = 7; i < 10; i++) send_byte(nom_bytes[i]);
      check("nom_hold_before_cs", 32'(cpu_hold), 32'd1);
      send_byte(8'h06);
      check("nom_done", 32'(done), 32'd1);
      check("nom_hold", 32'(cpu_hold), 32'd0);
      check("nom_error", 32'(error), 32'd0);
      check_nominal_writes("nom");
      send_byte(8'h55);
      check("done_ignores_rx", 32'(done), 32'd1);
      pulse_restart();
      check("rst_done", 32'(done), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      $display("txn nominal load done");

      // Checksum mismatch.
      clear_log();
      send_nominal(8'h07);
      check_nominal_writes("bad_cs");
      check("bad_cs_error", 32'(error), 32'd1);
      check("bad_cs_code", 32'(err_code), 32'd3);
      check("bad_cs_hold", 32'(cpu_hold), 32'd1);
      check("bad_cs_done", 32'(done), 32'd0);
      pulse_restart();
      check("bad_cs_rst_error", 32'(error), 32'd0);
      check("bad_cs_rst_code", 32'(err_code), 32'd0);
      check("bad_cs_rst_hold", 32'(cpu_hold), 32'd1);
      $display("txn checksum mismatch done");

      // N = 257 rejected.
      clear_log();
      send_byte(8'h01);
      send_byte(8'h01);
      check("len257_error", 32'(error), 32'd1);
      check("len257_code", 32'(err_code), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("len257_nowrite", 32'(wr_addr_q.size()), 32'd0);
      pulse_restart();
      $display("txn length 257 done");

      // N = 256 accepted; bytes are k mod 256, checksum 4*sum(0..255) mod 256 = 0.
      clear_log();
      send_byte(8'h00);
      send_byte(8'h01);
      for (int k = 0; k < 1024; k++) send_byte(8'(k));
      send_byte(8'h00);
      check("len256_done", 32'(done), 32'd1);
      check("len256_wcount", 32'(wr_addr_q.size()), 32'd256);
      if (wr_addr_q.size() == 256) begin
         check("len256_last_addr", wr_addr_q[255], 32'h3FC);
         check("len256_last_data", wr_data_q[255], 32'hFFFEFDFC);
         check("len256_w1_data", wr_data_q[1], 32'h07060504);
      end
      pulse_restart();
      $display("txn length 256 done");

      // Zero-length images.
      clear_log();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("zero_done", 32'(done), 32'd1);
      check("zero_hold", 32'(cpu_hold), 32'd0);
      check("zero_nowrite", 32'(wr_addr_q.size()), 32'd0);
      pulse_restart();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      check("zero_bad_code", 32'(err_code), 32'd3);
      check("zero_bad_done", 32'(done), 32'd0);
      pulse_restart();
      $display("txn zero length done");

      // Timeout after 16 idle clocks, no partial write.
      clear_log();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
      repeat (15) @(posedge clk);
      #1;
      check("to_not_yet", 32'(error), 32'd0);
      @(posedge clk); #1;
      check("to_error", 32'(error), 32'd1);
      check("to_code", 32'(err_code), 32'd2);
      check("to_nowrite", 32'(wr_addr_q.size()), 32'd0);
      pulse_restart();
      $display("txn timeout done");

      // Byte on clock 15 restarts the idle count.
      send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
      repeat (14) @(posedge clk);
      #1;
      send_byte(8'hBB);
      check("to_saved", 32'(error), 32'd0);
      repeat (15) @(posedge clk);
      #1;
      check("to_saved_late", 32'(error), 32'd0);
      @(posedge clk); #1;
      check("to_saved_fire", 32'(err_code), 32'd2);
      pulse_restart();
      $display("txn timeout rescue done");

      // Reset between payload bytes 2 and 3 of word 1.
      clear_log();
      for (int i = 0; i < 8; i++) send_byte(nom_bytes[i]);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_log();
      send_nominal(8'h06);
      check("midrst_done", 32'(done), 32'd1);
      check_nominal_writes("midrst");
      $display("txn reset mid-load done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory's write port from a serial byte stream (UART receiver output) while holding the CPU in reset. It parses a length-prefixed, checksummed image, assembles little-endian 32-bit words, and issues one write per word at word-aligned byte addresses. It releases the CPU hold only after the checksum verifies. It sits between the UART receiver and the instruction memory, and is the write-side counterpart of the core's combinational fetch port.

## Interface

- MEM_WORDS, 256, instruction memory depth in words; image lengths above this are rejected
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes once a load has started
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rx_data  input  8  received byte, valid only when rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte; no backpressure
- restart  input  1  one-cycle pulse; returns the loader from DONE or ERROR to IDLE
- mem_we  output  1  write strobe to instruction memory, one cycle per word
- mem_addr  output  32  byte address of the write, always word aligned (bits [1:0]=0)
- mem_wdata  output  32  word to write, {b3,b2,b1,b0}
- cpu_hold  output  1  1 = keep the CPU in reset
- done  output  1  image loaded and verified (level)
- error  output  1  load failed (level)
- err_code  output  2  0 none, 1 length > MEM_WORDS, 2 timeout, 3 checksum mismatch

## Operation

- Image format on the byte stream:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N payload bytes, little-endian per word.
  - One checksum byte: sum of all payload bytes mod 256. Length bytes are excluded from the sum.
- States:
  - IDLE: on rx_valid, capture LEN_LO and go to LEN_HI.
  - LEN_HI: on rx_valid, form N.
    - N > MEM_WORDS: ERROR, err_code=1.
    - N = 0: CHECK.
    - Otherwise: DATA. Clear the word index, byte lane and checksum.
  - DATA: each rx_valid stores the byte in lane 0..3 and adds it to the 8-bit checksum.
    - On lane 3, a word write is issued.
    - After word N-1 is written, go to CHECK.
  - CHECK: on rx_valid, compare the byte to the running checksum.
    - Equal: DONE.
    - Not equal: ERROR, err_code=3.
  - DONE: cpu_hold=0, done=1; rx_valid is ignored.
  - ERROR: cpu_hold=1, error=1; rx_valid is ignored.
- restart in DONE or ERROR:
  - Go to IDLE; clear done, error and err_code.
  - cpu_hold returns to 1.
  - Memory contents are untouched.
- restart in any other state: ignored.
- Timeout:
  - The idle counter clears on every rx_valid and is held at 0 in IDLE, DONE and ERROR.
  - In LEN_HI, DATA or CHECK, reaching TIMEOUT_CYCLES clocks without rx_valid goes to ERROR, err_code=2.
- Words already written before an error stay in memory; no rollback.
- Checksum arithmetic is 8-bit wrap-around. N=0 requires checksum byte 0x00.

## Timing

- Reset values (asynchronous, immediate):
  - Every output is 0 except cpu_hold=1.
  - State is IDLE; all counters and the checksum are 0.
- Write latency: mem_we is high for exactly one cycle, in the cycle after the rx_valid of lane-3. mem_addr = 4*word_index and mem_wdata = the assembled word are valid in that same cycle.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Maximum one write per 4 input bytes; the memory write port must accept a write every cycle.
- Status timing, registered, one cycle after the deciding rx_valid:
  - done and error assert.
  - cpu_hold deasserts on entry to DONE.
- Timeout fires on the clock edge at which the idle counter would reach TIMEOUT_CYCLES. error is visible the following cycle.
- Simultaneous rx_valid and timeout edge: the byte wins and the counter clears.
- Reset asserted mid-load:
  - Immediate return to IDLE; any in-flight mem_we is dropped.
  - cpu_hold=1.
  - A partially assembled word is discarded.

## Test plan

- Nominal load: bytes 02 00, 13 00 50 00, 93 00 10 00, checksum 0x06.
  - Writes (addr 0x0, data 0x00500013) then (addr 0x4, data 0x00100093), one cycle each.
  - done=1 and cpu_hold=0 one cycle after the checksum byte.
- Checksum mismatch: same image with checksum 0x07.
  - Both writes still occur.
  - error=1, err_code=3, cpu_hold stays 1.
  - restart pulse: done=error=0, cpu_hold=1, state IDLE.
- Length limit with MEM_WORDS=256:
  - Length 01 01 (N=257): ERROR err_code=1 after the second byte; no mem_we ever.
  - Length 00 01 (N=256): accepted; the last write is at addr 0x3FC.
- Zero-length image: 00 00 then checksum 00 gives DONE; no writes. Checksum 01 gives err_code=3.
- Timeout with TIMEOUT_CYCLES=16:
  - After LEN and 2 payload bytes, rx_valid stops. error=1, err_code=2 after 16 idle clocks; no partial write.
  - A byte arriving on clock 15 resets the count instead.
- Reset mid-load: assert rst_n=0 between payload bytes 2 and 3 of word 1.
  - All outputs return to reset values immediately and cpu_hold=1.
  - A fresh nominal image afterwards loads correctly from addr 0x0.
